// File: rtl/rs_pkg.sv
// Shared RS(255,223) / GF(2^8) definitions for the encoder and the
// receive-side syndrome checker.
//   RS_N, RS_K, RS_NPAR : code geometry in symbols
//   RS_FCR              : first consecutive root, roots are alpha^(RS_FCR+j)
//   RS_PRIM_POLY        : field polynomial x^8+x^4+x^3+x^2+1
//   gf_mul_const        : a * c in GF(2^8); with c constant it folds to an XOR matrix
//   gf_alpha_pow        : alpha^k, k taken modulo 255
package rs_pkg;

    localparam int         RS_N         = 255;
    localparam int         RS_K         = 223;
    localparam int         RS_NPAR      = 32;
    localparam int         RS_FCR       = 0;
    localparam logic [8:0] RS_PRIM_POLY = 9'h11D;

    typedef logic [7:0] gf_sym_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } rs_state_t;

    // Multiply by alpha (x): shift left and fold the x^8 term back in.
    function automatic gf_sym_t gf_xtime(input gf_sym_t a);
        gf_sym_t r;
        r = {a[6:0], 1'b0} ^ (a[7] ? RS_PRIM_POLY[7:0] : 8'h00);
        return r;
    endfunction

    // Shift-and-add product; every partial product is a fixed XOR of a's bits.
    function automatic gf_sym_t gf_mul_const(input gf_sym_t a, input gf_sym_t c);
        gf_sym_t acc;
        gf_sym_t p;
        acc = 8'h00;
        p   = a;
        for (int i = 0; i < 8; i++) begin
            if (c[i]) begin
                acc = acc ^ p;
            end
            p = gf_xtime(p);
        end
        return acc;
    endfunction

    function automatic gf_sym_t gf_alpha_pow(input int k);
        gf_sym_t r;
        int      e;
        r = 8'h01;
        e = k % RS_N;
        if (e < 32'sd0) begin
            e = e + RS_N;
        end
        for (int i = 0; i < RS_N; i++) begin
            if (i < e) begin
                r = gf_xtime(r);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rs_syndrome_cell.sv
// One syndrome accumulator S_j with its constant multiplier (Horner step).
//   clk, rst  : clock, synchronous active-high reset
//   clear     : zero the accumulator (new codeword armed)
//   enable    : accept one received symbol
//   data      : received symbol
//   synd      : registered S_j
//   synd_next : S_j*root ^ data, the value S_j takes if this symbol is accepted
module rs_syndrome_cell
    import rs_pkg::*;
#(
    parameter int ROOT_POW = 0
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    clear,
    input  logic    enable,
    input  gf_sym_t data,
    output gf_sym_t synd,
    output gf_sym_t synd_next
);

    localparam gf_sym_t ROOT = gf_alpha_pow(ROOT_POW);

    gf_sym_t synd_r;
    gf_sym_t horner_s;

    assign horner_s  = gf_mul_const(synd_r, ROOT) ^ data;
    assign synd      = synd_r;
    assign synd_next = horner_s;

    // Syndrome accumulator: clear on arm, Horner step on each accepted symbol.
    always_ff @(posedge clk) begin
        if (rst) begin
            synd_r <= 8'h00;
        end else if (clear) begin
            synd_r <= 8'h00;
        end else if (enable) begin
            synd_r <= horner_s;
        end
    end

endmodule

// File: rtl/rs_syndrome_check.sv
// RS(255,223) receive-side syndrome checker.
// Takes one 255-symbol codeword (start pulse, then symbols qualified by
// data_enable, highest degree first), forwards the 223 message symbols with
// one cycle of latency, and one cycle after the last symbol pulses synd_val
// with the 32 syndromes and an error flag.
//   clk, rst                      : clock, synchronous active-high reset
//   src_decoder_start_decode      : arm a new codeword (aborts one in progress)
//   src_decoder_data_enable/data  : received symbol stream
//   decoder_src_decoding          : codeword armed or in progress
//   decoder_dst_data_val/data     : forwarded message symbols
//   decoder_dst_synd_val          : one-cycle result pulse
//   decoder_dst_err               : some syndrome nonzero
//   decoder_dst_synd              : S_j in bits [8j+7:8j]
module rs_syndrome_check
    import rs_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 src_decoder_start_decode,
    input  logic                 src_decoder_data_enable,
    input  logic [7:0]           src_decoder_data,
    output logic                 decoder_src_decoding,
    output logic                 decoder_dst_data_val,
    output logic [7:0]           decoder_dst_data,
    output logic                 decoder_dst_synd_val,
    output logic                 decoder_dst_err,
    output logic [RS_NPAR*8-1:0] decoder_dst_synd
);

    rs_state_t             state_r;
    rs_state_t             state_s;
    logic [7:0]            cnt_r;
    logic                  accept_s;
    logic                  last_s;
    logic                  decoding_r;
    logic                  dst_val_r;
    logic [7:0]            dst_data_r;
    logic                  synd_val_r;
    logic                  err_r;
    logic [RS_NPAR*8-1:0]  synd_cur_s;
    logic [RS_NPAR*8-1:0]  synd_next_s;

    // A symbol counts only in RUN and only when no start competes with it.
    always_comb begin
        accept_s = 1'b0;
        last_s   = 1'b0;
        if ((state_r == ST_RUN) && src_decoder_data_enable && !src_decoder_start_decode) begin
            accept_s = 1'b1;
            last_s   = (cnt_r == 8'(RS_N - 1));
        end else begin
            accept_s = 1'b0;
            last_s   = 1'b0;
        end
    end

    // Next-state logic; start always (re)enters RUN, DONE lasts one cycle.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (src_decoder_start_decode) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (src_decoder_start_decode) begin
                    state_s = ST_RUN;
                end else if (last_s) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_DONE: begin
                if (src_decoder_start_decode) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State register plus status outputs registered from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            decoding_r <= 1'b0;
            synd_val_r <= 1'b0;
        end else begin
            state_r    <= state_s;
            decoding_r <= (state_s != ST_IDLE);
            synd_val_r <= (state_s == ST_DONE);
        end
    end

    // Symbol position within the codeword.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= 8'd0;
        end else if (src_decoder_start_decode) begin
            cnt_r <= 8'd0;
        end else if (accept_s) begin
            cnt_r <= cnt_r + 8'd1;
        end
    end

    // Message forwarding; parity positions (cnt >= RS_K) are swallowed.
    always_ff @(posedge clk) begin
        if (rst) begin
            dst_val_r  <= 1'b0;
            dst_data_r <= 8'h00;
        end else if (accept_s && (cnt_r < 8'(RS_K))) begin
            dst_val_r  <= 1'b1;
            dst_data_r <= src_decoder_data;
        end else begin
            dst_val_r  <= 1'b0;
        end
    end

    // Error flag is taken from the syndromes being written on the last symbol,
    // so it is valid in the same cycle as synd_val and held until re-arm.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_r <= 1'b0;
        end else if (src_decoder_start_decode) begin
            err_r <= 1'b0;
        end else if (last_s) begin
            err_r <= |synd_next_s;
        end
    end

    for (genvar j = 0; j < RS_NPAR; j++) begin : g_cell
        rs_syndrome_cell #(
            .ROOT_POW (RS_FCR + j)
        ) u_cell (
            .clk       (clk),
            .rst       (rst),
            .clear     (src_decoder_start_decode),
            .enable    (accept_s),
            .data      (src_decoder_data),
            .synd      (synd_cur_s[8*j +: 8]),
            .synd_next (synd_next_s[8*j +: 8])
        );
    end

    assign decoder_src_decoding = decoding_r;
    assign decoder_dst_data_val = dst_val_r;
    assign decoder_dst_data     = dst_data_r;
    assign decoder_dst_synd_val = synd_val_r;
    assign decoder_dst_err      = err_r;
    assign decoder_dst_synd     = synd_cur_s;

endmodule

// File: tb/tb_rs_syndrome_check.sv
// Scoreboard bench for rs_syndrome_check. Reference syndromes come from direct
// polynomial evaluation using exp/log tables; codewords come from a
// polynomial-division encoder built from the generator's roots.
module tb_rs_syndrome_check;
    import rs_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         en;
    logic [7:0]   din;
    logic         decoding;
    logic         dst_val;
    logic [7:0]   dst_data;
    logic         synd_val;
    logic         err;
    logic [255:0] synd;

    rs_syndrome_check dut (
        .clk                      (clk),
        .rst                      (rst),
        .src_decoder_start_decode (start),
        .src_decoder_data_enable  (en),
        .src_decoder_data         (din),
        .decoder_src_decoding     (decoding),
        .decoder_dst_data_val     (dst_val),
        .decoder_dst_data         (dst_data),
        .decoder_dst_synd_val     (synd_val),
        .decoder_dst_err          (err),
        .decoder_dst_synd         (synd)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         err;
        logic [255:0] synd;
        int           cyc;
    } res_t;

    res_t       res_q[$];
    logic [7:0] fwd_q[$];
    int         n_tests = 0;
    int         n_fail  = 0;
    int         cyc     = 0;
    int         exp_t[0:254];
    int         log_t[0:255];
    int         gen[0:32];
    logic [7:0] base_cw[0:254];
    logic [7:0] work_cw[0:254];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    function automatic int gmul(input int a, input int b);
        if (a == 0 || b == 0) return 0;
        return exp_t[(log_t[a] + log_t[b]) % 255];
    endfunction

    task automatic build_tables();
        int e;
        e = 1;
        for (int i = 0; i < 255; i++) begin
            exp_t[i] = e;
            log_t[e] = i;
            e = e << 1;
            if ((e & 256) != 0) e = e ^ 'h11D;
        end
        log_t[0] = 0;
        for (int k = 0; k <= 32; k++) gen[k] = 0;
        gen[0] = 1;
        for (int j = 0; j < 32; j++) begin
            int r;
            r = exp_t[(RS_FCR + j) % 255];
            for (int k = 32; k >= 1; k--) gen[k] = gen[k-1] ^ gmul(gen[k], r);
            gen[0] = gmul(gen[0], r);
        end
    endtask

    // Systematic encode of work_cw[0..222] into parity work_cw[223..254].
    task automatic encode_work();
        int rem[0:31];
        int fb;
        for (int k = 0; k < 32; k++) rem[k] = 0;
        for (int i = 0; i < 223; i++) begin
            fb = int'(work_cw[i]) ^ rem[31];
            for (int k = 31; k >= 1; k--) rem[k] = rem[k-1] ^ gmul(fb, gen[k]);
            rem[0] = gmul(fb, gen[0]);
        end
        for (int k = 0; k < 32; k++) work_cw[223 + k] = 8'(rem[31 - k]);
    endtask

    // S_j = sum_i c_i * (alpha^(FCR+j))^(254-i)
    function automatic logic [255:0] model_synd();
        logic [255:0] v;
        int s;
        v = '0;
        for (int j = 0; j < 32; j++) begin
            s = 0;
            for (int i = 0; i < 255; i++)
                s = s ^ gmul(int'(work_cw[i]), exp_t[((RS_FCR + j) * (254 - i)) % 255]);
            v[8*j +: 8] = 8'(s);
        end
        return v;
    endfunction

    task automatic drive(input logic st, input logic e, input logic [7:0] d);
        @(negedge clk);
        start = st;
        en    = e;
        din   = d;
    endtask

    // Send work_cw (first nsym symbols); tail=0 leaves the next start to land in DONE.
    task automatic send(input int nsym, input int maxgap, input bit tail);
        res_t r;
        int   g;
        r.synd = model_synd();
        r.err  = |r.synd;
        drive(1'b1, 1'b1, 8'($urandom));
        drive(1'b0, 1'b0, 8'($urandom));
        chk("decoding_armed", 256'(decoding), 256'(1'b1));
        for (int i = 0; i < nsym; i++) begin
            g = (maxgap > 0) ? int'($urandom_range(1, maxgap)) : 0;
            repeat (g) drive(1'b0, 1'b0, 8'($urandom));
            drive(1'b0, 1'b1, work_cw[i]);
            if (i < RS_K) fwd_q.push_back(work_cw[i]);
            if (i == RS_N - 1) begin
                r.cyc = cyc + 1;
                res_q.push_back(r);
            end
        end
        if (tail) begin
            drive(1'b0, 1'b0, 8'h00);
            drive(1'b0, 1'b0, 8'h00);
            chk("decoding_idle", 256'(decoding), 256'(1'b0));
            if (nsym == RS_N) chk("err_held", 256'(err), 256'(r.err));
        end
    endtask

    task automatic load_base();
        for (int i = 0; i < 255; i++) work_cw[i] = base_cw[i];
    endtask

    // Monitor: pops expectations whenever the DUT presents an output.
    always @(posedge clk) begin
        #1;
        if (dst_val) begin
            if (fwd_q.size() == 0) begin
                chk("fwd_unexpected", 256'(dst_data), 256'h1FF);
            end else begin
                logic [7:0] e8;
                e8 = fwd_q.pop_front();
                chk("fwd_data", 256'(dst_data), 256'(e8));
            end
        end
        if (synd_val) begin
            if (res_q.size() == 0) begin
                chk("synd_val_unexpected", 256'(synd_val), 256'(1'b0));
            end else begin
                res_t r;
                r = res_q.pop_front();
                chk("synd_vec", synd, r.synd);
                chk("synd_err", 256'(err), 256'(r.err));
                chk("synd_latency", 256'(cyc), 256'(r.cyc));
            end
        end
    end

    initial begin
        logic [255:0] apow;
        int ne;
        rst = 1'b1; start = 1'b0; en = 1'b0; din = 8'h00;
        build_tables();
        for (int i = 0; i < 223; i++) work_cw[i] = 8'(i + 1);
        encode_work();
        for (int i = 0; i < 255; i++) base_cw[i] = work_cw[i];

        repeat (3) @(negedge clk);
        chk("reset_ctl", 256'({decoding, dst_val, dst_data, synd_val, err}), 256'(0));
        chk("reset_synd", synd, 256'(0));
        rst = 1'b0;

        // data_enable while idle is ignored
        repeat (3) drive(1'b0, 1'b1, 8'($urandom));

        // all-zero codeword
        for (int i = 0; i < 255; i++) work_cw[i] = 8'h00;
        send(255, 0, 1'b1);

        // clean encoded codeword, message 1..223
        load_base();
        send(255, 0, 1'b1);

        // degree-0 parity symbol corrupted: every S_j = 0x5A
        load_base();
        work_cw[254] = work_cw[254] ^ 8'h5A;
        send(255, 0, 1'b1);

        // degree-254 symbol corrupted by 0x01
        load_base();
        work_cw[0] = work_cw[0] ^ 8'h01;
        send(255, 0, 1'b1);
        for (int j = 0; j < 32; j++) apow[8*j +: 8] = gf_alpha_pow(254 * (RS_FCR + j));
        chk("alpha_pow_synd", synd, apow);

        // clean codeword with 1-5 cycle gaps
        load_base();
        send(255, 5, 1'b1);

        // abort after 100 symbols, then a full clean codeword
        load_base();
        send(100, 0, 1'b0);
        send(255, 0, 1'b1);

        // random messages with random errors, back to back (start lands in DONE)
        for (int t = 0; t < 3; t++) begin
            for (int i = 0; i < 223; i++) work_cw[i] = 8'($urandom);
            encode_work();
            ne = int'($urandom_range(0, 3));
            for (int k = 0; k < ne; k++) begin
                int p;
                p = int'($urandom_range(0, 254));
                work_cw[p] = work_cw[p] ^ 8'($urandom_range(1, 255));
            end
            send(255, 0, (t == 2));
        end

        // reset in the middle of a codeword
        load_base();
        send(50, 0, 1'b0);
        @(negedge clk);
        rst = 1'b1; start = 1'b0; en = 1'b0;
        @(negedge clk);
        chk("midreset_ctl", 256'({decoding, dst_val, dst_data, synd_val, err}), 256'(0));
        chk("midreset_synd", synd, 256'(0));
        rst = 1'b0;

        repeat (5) drive(1'b0, 1'b0, 8'h00);
        chk("fwd_drain", 256'(fwd_q.size()), 256'(0));
        chk("res_drain", 256'(res_q.size()), 256'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
